// File: rtl/mips_decode_stage.sv
// Buffered MIPS-I decode stage: fetch queue, combinational decode of the queue head and a
// registered control bundle on a valid/ready output, with an exception hold and a flush.
module mips_decode_stage #(
  parameter int DEPTH          = 4,
  parameter int PC_W           = 32,
  parameter int SUPPORT_MULDIV = 1
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [PC_W-1:0]            in_pc,
  input  logic                       flush,
  input  logic                       exc_ack,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [31:0]                out_inst,
  output logic [3:0]                 out_alu_sel,
  output logic                       out_alu_uns,
  output logic                       out_we,
  output logic                       out_desreg,
  output logic                       out_op1src,
  output logic [1:0]                 out_op2src,
  output logic                       out_isbranch,
  output logic                       out_isjump,
  output logic                       out_jal,
  output logic                       out_jalr,
  output logic                       out_load_imm,
  output logic                       out_mem2reg,
  output logic                       out_load_se,
  output logic [1:0]                 out_ld_size,
  output logic [1:0]                 out_st_size,
  output logic [2:0]                 out_md_op,
  output logic [1:0]                 out_exc,
  output logic                       exc_pending,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_NOR = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8;
  localparam logic [3:0] ALU_SRL = 4'd9;
  localparam logic [3:0] ALU_SRA = 4'd10;

  typedef struct packed {
    logic [3:0] alu_sel;
    logic       alu_uns;
    logic       we;
    logic       desreg;
    logic       op1src;
    logic [1:0] op2src;
    logic       isbranch;
    logic       isjump;
    logic       jal;
    logic       jalr;
    logic       load_imm;
    logic       mem2reg;
    logic       load_se;
    logic [1:0] ld_size;
    logic [1:0] st_size;
    logic [2:0] md_op;
    logic [1:0] exc;
  } ctrl_t;

  logic [PC_W+31:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_exc_pending;
  logic             r_out_valid;
  logic [PC_W-1:0]  r_out_pc;
  logic [31:0]      r_out_inst;
  ctrl_t            r_ctrl;

  logic             w_push;
  logic             w_load;
  logic [31:0]      w_head_inst;
  logic [PC_W-1:0]  w_head_pc;
  logic [5:0]       w_op;
  logic [5:0]       w_funct;
  logic [4:0]       w_rt;
  logic             w_ri;
  logic             w_md_ok;
  ctrl_t            w_dec;

  assign in_ready    = (r_count < CNT_W'(DEPTH));
  assign w_push      = in_valid && in_ready && !flush;
  assign w_load      = (r_count != '0) && !r_exc_pending && (!r_out_valid || out_ready) && !flush;
  assign w_head_inst = r_mem[r_rptr][31:0];
  assign w_head_pc   = r_mem[r_rptr][PC_W+31:32];
  assign w_op        = w_head_inst[31:26];
  assign w_rt        = w_head_inst[20:16];
  assign w_funct     = w_head_inst[5:0];
  assign w_md_ok     = (SUPPORT_MULDIV != 0);

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {in_pc, in_inst};
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_load) r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_load)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_load) r_count <= r_count - CNT_W'(1);
    end
  end

  always_comb begin
    w_dec = '0;
    w_ri  = 1'b0;
    case (w_op)
      6'h00: begin
        case (w_funct)
          6'h00: begin w_dec.we = 1'b1; w_dec.op1src = 1'b1; w_dec.alu_sel = ALU_SLL; end
          6'h02: begin w_dec.we = 1'b1; w_dec.op1src = 1'b1; w_dec.alu_sel = ALU_SRL; end
          6'h03: begin w_dec.we = 1'b1; w_dec.op1src = 1'b1; w_dec.alu_sel = ALU_SRA; end
          6'h04: begin w_dec.we = 1'b1; w_dec.alu_sel = ALU_SLL; end
          6'h06: begin w_dec.we = 1'b1; w_dec.alu_sel = ALU_SRL; end
          6'h07: begin w_dec.we = 1'b1; w_dec.alu_sel = ALU_SRA; end
          6'h08: w_dec.isjump = 1'b1;
          6'h09: begin w_dec.isjump = 1'b1; w_dec.jalr = 1'b1; w_dec.jal = 1'b1; w_dec.we = 1'b1; end
          6'h0C: w_dec.exc = 2'b01;
          6'h10, 6'h12: begin
            if (w_md_ok) begin
              w_dec.we    = 1'b1;
              w_dec.md_op = w_funct[1] ? 3'b110 : 3'b101;
            end else w_ri = 1'b1;
          end
          6'h18, 6'h19, 6'h1A, 6'h1B: begin
            if (w_md_ok) w_dec.md_op = 3'(w_funct[1:0]) + 3'd1;
            else         w_ri = 1'b1;
          end
          6'h20: begin w_dec.we = 1'b1; w_dec.alu_sel = ALU_ADD; end
          6'h21: begin w_dec.we = 1'b1; w_dec.alu_sel = ALU_ADD; w_dec.alu_uns = 1'b1; end
          6'h22: begin w_dec.we = 1'b1; w_dec.alu_sel = ALU_SUB; end
          6'h23: begin w_dec.we = 1'b1; w_dec.alu_sel = ALU_SUB; w_dec.alu_uns = 1'b1; end
          6'h24: begin w_dec.we = 1'b1; w_dec.alu_sel = ALU_AND; end
          6'h25: begin w_dec.we = 1'b1; w_dec.alu_sel = ALU_OR;  end
          6'h26: begin w_dec.we = 1'b1; w_dec.alu_sel = ALU_XOR; end
          6'h27: begin w_dec.we = 1'b1; w_dec.alu_sel = ALU_NOR; end
          6'h2A: begin w_dec.we = 1'b1; w_dec.alu_sel = ALU_SLT; end
          6'h2B: begin w_dec.we = 1'b1; w_dec.alu_sel = ALU_SLT; w_dec.alu_uns = 1'b1; end
          default: w_ri = 1'b1;
        endcase
      end
      6'h01: begin
        case (w_rt)
          5'h00, 5'h01: w_dec.isbranch = 1'b1;
          5'h10, 5'h11: begin w_dec.isbranch = 1'b1; w_dec.we = 1'b1; w_dec.jal = 1'b1; end
          default: w_ri = 1'b1;
        endcase
      end
      6'h02: w_dec.isjump = 1'b1;
      6'h03: begin w_dec.isjump = 1'b1; w_dec.jal = 1'b1; w_dec.we = 1'b1; end
      6'h04, 6'h05, 6'h06, 6'h07: begin w_dec.isbranch = 1'b1; w_dec.alu_sel = ALU_SUB; end
      6'h08, 6'h09, 6'h0A, 6'h0B: begin
        w_dec.we      = 1'b1;
        w_dec.desreg  = 1'b1;
        w_dec.op2src  = 2'b01;
        w_dec.alu_sel = w_op[1] ? ALU_SLT : ALU_ADD;
        w_dec.alu_uns = w_op[0];
      end
      6'h0C, 6'h0D, 6'h0E: begin
        w_dec.we      = 1'b1;
        w_dec.desreg  = 1'b1;
        w_dec.op2src  = 2'b10;
        w_dec.alu_sel = (w_op[1:0] == 2'b00) ? ALU_AND : (w_op[1:0] == 2'b01) ? ALU_OR : ALU_XOR;
      end
      6'h0F: begin w_dec.we = 1'b1; w_dec.desreg = 1'b1; w_dec.op2src = 2'b10; w_dec.load_imm = 1'b1; end
      // Access size follows op[1:0]: 00 byte, 01 half, 11 word; op[2] marks unsigned loads.
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        w_dec.we      = 1'b1;
        w_dec.desreg  = 1'b1;
        w_dec.op2src  = 2'b01;
        w_dec.alu_sel = ALU_ADD;
        w_dec.mem2reg = 1'b1;
        w_dec.ld_size = (w_op[1:0] == 2'b11) ? 2'b11 : w_op[1:0] + 2'b01;
        w_dec.load_se = !w_op[2] && (w_op[1:0] != 2'b11);
      end
      6'h28, 6'h29, 6'h2B: begin
        w_dec.op2src  = 2'b01;
        w_dec.alu_sel = ALU_ADD;
        w_dec.st_size = (w_op[1:0] == 2'b11) ? 2'b11 : w_op[1:0] + 2'b01;
      end
      default: w_ri = 1'b1;
    endcase
    if (w_ri) begin
      w_dec     = '0;
      w_dec.exc = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_inst  <= '0;
      r_ctrl      <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_pc    <= w_head_pc;
      r_out_inst  <= w_head_inst;
      r_ctrl      <= w_dec;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Setting the hold on an exception load wins over a coincident acknowledge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                           r_exc_pending <= 1'b0;
    else if (flush)                       r_exc_pending <= 1'b0;
    else if (w_load && w_dec.exc != 2'b00) r_exc_pending <= 1'b1;
    else if (exc_ack)                     r_exc_pending <= 1'b0;
  end

  assign out_valid    = r_out_valid;
  assign out_pc       = r_out_pc;
  assign out_inst     = r_out_inst;
  assign out_alu_sel  = r_ctrl.alu_sel;
  assign out_alu_uns  = r_ctrl.alu_uns;
  assign out_we       = r_ctrl.we;
  assign out_desreg   = r_ctrl.desreg;
  assign out_op1src   = r_ctrl.op1src;
  assign out_op2src   = r_ctrl.op2src;
  assign out_isbranch = r_ctrl.isbranch;
  assign out_isjump   = r_ctrl.isjump;
  assign out_jal      = r_ctrl.jal;
  assign out_jalr     = r_ctrl.jalr;
  assign out_load_imm = r_ctrl.load_imm;
  assign out_mem2reg  = r_ctrl.mem2reg;
  assign out_load_se  = r_ctrl.load_se;
  assign out_ld_size  = r_ctrl.ld_size;
  assign out_st_size  = r_ctrl.st_size;
  assign out_md_op    = r_ctrl.md_op;
  assign out_exc      = r_ctrl.exc;
  assign exc_pending  = r_exc_pending;
  assign count        = r_count;

endmodule
